// File: rtl/pcie_h2c_axis_downsizer.sv
// Width converter: splits each wide H2C AXI-Stream beat into narrow lanes,
// skipping lanes with an all-zero keep group and marking tlast on the final one.
module pcie_h2c_axis_downsizer #(
   parameter int unsigned IN_W  = 256,
   parameter int unsigned OUT_W = 64
) (
   input  logic                user_clk_250,
   input  logic                sys_rst,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic [IN_W-1:0]     s_axis_tdata,
   input  logic [IN_W/8-1:0]   s_axis_tkeep,
   input  logic                s_axis_tlast,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [OUT_W-1:0]    m_axis_tdata,
   output logic [OUT_W/8-1:0]  m_axis_tkeep,
   output logic                m_axis_tlast,
   output logic                err_keep,
   output logic [31:0]         pkt_cnt
);
   localparam int unsigned RATIO  = IN_W / OUT_W;
   localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned IN_KW  = IN_W / 8;
   localparam int unsigned OUT_KW = OUT_W / 8;

   typedef enum logic {ST_EMPTY, ST_DRAIN} state_e;

   state_e              state_q, state_d;
   logic [IN_W-1:0]     buf_data_q, buf_data_d;
   logic [IN_KW-1:0]    buf_keep_q, buf_keep_d;
   logic                buf_last_q, buf_last_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic                final_q, final_d;
   logic                m_tvalid_q, m_tvalid_d;
   logic [OUT_W-1:0]    m_tdata_q, m_tdata_d;
   logic [OUT_KW-1:0]   m_tkeep_q, m_tkeep_d;
   logic                m_tlast_q, m_tlast_d;
   logic                err_keep_q, err_keep_d;
   logic [31:0]         pkt_cnt_q, pkt_cnt_d;

   logic [RATIO-1:0]    s_nz, b_nz;
   logic [LANE_W-1:0]   s_first, b_next;
   logic                s_accept, m_hs;

   // One bit per lane: keep group has at least one byte enabled
   function automatic logic [RATIO-1:0] grp_nz(input logic [IN_KW-1:0] keep);
      logic [RATIO-1:0] nz;
      nz = '0;
      for (int unsigned k = 0; k < RATIO; k++) nz[LANE_W'(k)] = |keep[k*OUT_KW +: OUT_KW];
      return nz;
   endfunction

   function automatic logic [LANE_W-1:0] first_from(input logic [RATIO-1:0] nz,
                                                   input int unsigned start);
      logic [LANE_W-1:0] ln;
      logic              found;
      ln    = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (!found && k >= start && nz[LANE_W'(k)]) begin
            ln    = LANE_W'(k);
            found = 1'b1;
         end
      end
      return ln;
   endfunction

   function automatic logic is_final(input logic [RATIO-1:0] nz, input logic [LANE_W-1:0] ln);
      logic fin;
      fin = 1'b1;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (k > 32'(ln) && nz[LANE_W'(k)]) fin = 1'b0;
      end
      return fin;
   endfunction

   function automatic logic [OUT_W-1:0] lane_data(input logic [IN_W-1:0] data,
                                                 input logic [LANE_W-1:0] ln);
      logic [OUT_W-1:0] d;
      d = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (LANE_W'(k) == ln) d = data[k*OUT_W +: OUT_W];
      end
      return d;
   endfunction

   function automatic logic [OUT_KW-1:0] lane_keep(input logic [IN_KW-1:0] keep,
                                                  input logic [LANE_W-1:0] ln);
      logic [OUT_KW-1:0] kp;
      kp = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (LANE_W'(k) == ln) kp = keep[k*OUT_KW +: OUT_KW];
      end
      return kp;
   endfunction

   // Low-aligned contiguous keep is of the form 2^n-1 (including all-zero)
   function automatic logic keep_contig(input logic [IN_KW-1:0] keep);
      logic [IN_KW-1:0] inc;
      inc = keep + IN_KW'(1);
      return (keep & inc) == '0;
   endfunction

   // Input is taken when idle, or in the final lane as it hands off downstream
   always_comb begin
      s_axis_tready = !sys_rst && ((state_q == ST_EMPTY) || (final_q && m_axis_tready));
   end

   always_comb begin
      state_d    = state_q;
      buf_data_d = buf_data_q;
      buf_keep_d = buf_keep_q;
      buf_last_d = buf_last_q;
      lane_d     = lane_q;
      final_d    = final_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tkeep_d  = m_tkeep_q;
      m_tlast_d  = m_tlast_q;
      err_keep_d = err_keep_q;
      pkt_cnt_d  = pkt_cnt_q;

      s_accept = s_axis_tvalid && s_axis_tready;
      m_hs     = m_tvalid_q && m_axis_tready;
      s_nz     = grp_nz(s_axis_tkeep);
      s_first  = first_from(s_nz, 0);
      b_nz     = grp_nz(buf_keep_q);
      b_next   = first_from(b_nz, 32'(lane_q) + 1);

      if (m_hs) begin
         if (m_tlast_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
         if (!final_q) begin
            lane_d    = b_next;
            final_d   = is_final(b_nz, b_next);
            m_tdata_d = lane_data(buf_data_q, b_next);
            m_tkeep_d = lane_keep(buf_keep_q, b_next);
            m_tlast_d = buf_last_q && is_final(b_nz, b_next);
         end else begin
            m_tvalid_d = 1'b0;
            state_d    = ST_EMPTY;
         end
      end

      if (s_accept) begin
         buf_data_d = s_axis_tdata;
         buf_keep_d = s_axis_tkeep;
         buf_last_d = s_axis_tlast;
         if (!keep_contig(s_axis_tkeep)) err_keep_d = 1'b1;
         if (|s_nz) begin
            state_d    = ST_DRAIN;
            m_tvalid_d = 1'b1;
            lane_d     = s_first;
            final_d    = is_final(s_nz, s_first);
            m_tdata_d  = lane_data(s_axis_tdata, s_first);
            m_tkeep_d  = lane_keep(s_axis_tkeep, s_first);
            m_tlast_d  = s_axis_tlast && is_final(s_nz, s_first);
         end else if (s_axis_tlast) begin
            // Empty closing beat still has to carry tlast downstream
            state_d    = ST_DRAIN;
            m_tvalid_d = 1'b1;
            lane_d     = '0;
            final_d    = 1'b1;
            m_tdata_d  = '0;
            m_tkeep_d  = '0;
            m_tlast_d  = 1'b1;
         end else begin
            state_d    = ST_EMPTY;
            m_tvalid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge user_clk_250) begin
      if (sys_rst) begin
         state_q    <= ST_EMPTY;
         buf_data_q <= '0;
         buf_keep_q <= '0;
         buf_last_q <= 1'b0;
         lane_q     <= '0;
         final_q    <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tlast_q  <= 1'b0;
         err_keep_q <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         buf_data_q <= buf_data_d;
         buf_keep_q <= buf_keep_d;
         buf_last_q <= buf_last_d;
         lane_q     <= lane_d;
         final_q    <= final_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tlast_q  <= m_tlast_d;
         err_keep_q <= err_keep_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tlast  = m_tlast_q;
   assign err_keep      = err_keep_q;
   assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_pcie_h2c_axis_downsizer.sv
// Scoreboard bench for pcie_h2c_axis_downsizer: random and directed H2C beats,
// expected narrow beats derived from keep groups and compared by a monitor.
module tb_pcie_h2c_axis_downsizer;
   localparam int unsigned IN_W   = 256;
   localparam int unsigned OUT_W  = 64;
   localparam int unsigned RATIO  = IN_W / OUT_W;
   localparam int unsigned IN_KW  = IN_W / 8;
   localparam int unsigned OUT_KW = OUT_W / 8;

   logic                clk = 1'b0;
   logic                sys_rst;
   logic                s_axis_tvalid;
   logic                s_axis_tready;
   logic [IN_W-1:0]     s_axis_tdata;
   logic [IN_KW-1:0]    s_axis_tkeep;
   logic                s_axis_tlast;
   logic                m_axis_tvalid;
   logic                m_axis_tready;
   logic [OUT_W-1:0]    m_axis_tdata;
   logic [OUT_KW-1:0]   m_axis_tkeep;
   logic                m_axis_tlast;
   logic                err_keep;
   logic [31:0]         pkt_cnt;

   always #2 clk = ~clk;

   pcie_h2c_axis_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .user_clk_250 (clk),
      .sys_rst      (sys_rst),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tkeep (s_axis_tkeep),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tlast (m_axis_tlast),
      .err_keep     (err_keep),
      .pkt_cnt      (pkt_cnt)
   );

   typedef struct packed {
      logic [OUT_W-1:0]  data;
      logic [OUT_KW-1:0] keep;
      logic              last;
   } nb_t;

   nb_t         exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned exp_pkts    = 0;
   int unsigned cyc         = 0;
   int          bp_mode     = 3;   // 0: always ready, 1: random, 3: driven by main
   logic        trk         = 1'b0;
   int unsigned acc_cyc     = 0;
   int unsigned out_first   = 0;
   int unsigned out_last    = 0;
   int unsigned out_cnt     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: every lane with a nonzero keep group becomes one narrow beat,
   // tlast rides on the highest such lane; an empty beat only survives if it closes a packet.
   function automatic void model_beat(input logic [IN_W-1:0] d, input logic [IN_KW-1:0] k,
                                      input logic l);
      int  hi;
      nb_t nb;
      hi = -1;
      for (int i = 0; i < RATIO; i++) if (k[i*OUT_KW +: OUT_KW] != '0) hi = i;
      if (hi < 0) begin
         if (l) begin
            nb.data = '0; nb.keep = '0; nb.last = 1'b1;
            exp_q.push_back(nb);
            exp_pkts++;
         end
         return;
      end
      for (int i = 0; i <= hi; i++) begin
         if (k[i*OUT_KW +: OUT_KW] != '0) begin
            nb.data = d[i*OUT_W +: OUT_W];
            nb.keep = k[i*OUT_KW +: OUT_KW];
            nb.last = l && (i == hi);
            exp_q.push_back(nb);
         end
      end
      if (l) exp_pkts++;
   endfunction

   // Call at posedge+#1; returns at posedge+#1 after the beat is taken
   task automatic send_beat(input logic [IN_W-1:0] d, input logic [IN_KW-1:0] k, input logic l);
      int n;
      n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      forever begin
         @(negedge clk);
         if (s_axis_tvalid && s_axis_tready) begin
            model_beat(d, k, l);
            if (trk && acc_cyc == 0) acc_cyc = cyc;
            break;
         end
         n++;
         if (n > 1000) begin
            chk("s_accept_timeout", 128'(0), 128'(1));
            break;
         end
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic logic [IN_W-1:0] rand_data();
      logic [IN_W-1:0] d;
      for (int i = 0; i < IN_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Downstream ready generator
   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp_mode == 0) m_axis_tready = 1'b1;
         else if (bp_mode == 1) m_axis_tready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops on every m handshake and checks stability while stalled
   initial begin
      nb_t  held, cur, exp;
      logic stalled;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (sys_rst) begin
            stalled = 1'b0;
            continue;
         end
         cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
         if (stalled) begin
            chk("stall_valid", 128'(m_axis_tvalid), 128'(1));
            chk("stall_stable", 128'(cur), 128'(held));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 128'(cur), 128'(0));
            end else begin
               exp = exp_q.pop_front();
               chk("beat", 128'(cur), 128'(exp));
            end
            if (trk) begin
               if (out_cnt == 0) out_first = cyc;
               out_last = cyc;
               out_cnt++;
            end
         end
         stalled = m_axis_tvalid && !m_axis_tready;
         held    = cur;
      end
   end

   initial begin
      logic [IN_W-1:0]  d;
      logic [IN_KW-1:0] k;
      logic [IN_KW:0]   wide;
      int               len, nb;

      sys_rst       = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_s_tready", 128'(s_axis_tready), 128'(0));
      chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
      @(posedge clk); #1;
      sys_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_tready", 128'(s_axis_tready), 128'(1));
      chk("post_rst_outputs", 128'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(0));
      chk("post_rst_err", 128'(err_keep), 128'(0));
      chk("post_rst_pkt", 128'(pkt_cnt), 128'(0));
      @(posedge clk); #1;
      bp_mode = 0;
      m_axis_tready = 1'b1;

      // Single full beat, lanes A,B,C,D
      d = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      send_beat(d, '1, 1'b1);
      wait_drain();
      chk("pkt_cnt_single", 128'(pkt_cnt), 128'(1));

      // Eight back-to-back full beats: latency 1, 32 beats with no bubbles
      trk = 1'b1;
      for (int b = 0; b < 8; b++) send_beat(rand_data(), '1, b == 7);
      wait_drain();
      trk = 1'b0;
      chk("b2b_count", 128'(out_cnt), 128'(32));
      chk("b2b_latency", 128'(out_first - acc_cyc), 128'(1));
      chk("b2b_span", 128'(out_last - out_first), 128'(31));

      // 20-byte closing beat
      send_beat(rand_data(), '1, 1'b0);
      send_beat(rand_data(), 32'h000F_FFFF, 1'b1);
      wait_drain();

      // 100 packets under random backpressure with contiguous partial tails
      bp_mode = 1;
      for (int p = 0; p < 100; p++) begin
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            if (b == len - 1) begin
               nb   = $urandom_range(0, IN_KW);
               wide = (33'(1) << nb) - 33'(1);
               k    = wide[IN_KW-1:0];
            end else begin
               k = '1;
            end
            send_beat(rand_data(), k, b == len - 1);
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
            end
         end
      end
      wait_drain();
      chk("pkt_cnt_random", 128'(pkt_cnt), 128'(exp_pkts));

      // Empty beats and non-contiguous keep
      bp_mode = 0;
      m_axis_tready = 1'b1;
      send_beat(rand_data(), '0, 1'b1);
      send_beat(rand_data(), '0, 1'b0);
      wait_drain();
      chk("err_before", 128'(err_keep), 128'(0));
      chk("pkt_cnt_empty", 128'(pkt_cnt), 128'(exp_pkts));
      send_beat(rand_data(), 32'h0000_FF0F, 1'b1);
      wait_drain();
      chk("err_after", 128'(err_keep), 128'(1));
      send_beat(rand_data(), 32'hF0F0_0F00, 1'b1);
      wait_drain();
      chk("err_sticky", 128'(err_keep), 128'(1));

      // Reset while lane 2 is pending
      bp_mode = 3;
      m_axis_tready = 1'b0;
      send_beat(rand_data(), '1, 1'b1);
      m_axis_tready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_axis_tready = 1'b0;
      sys_rst = 1'b1;
      exp_q.delete();
      exp_pkts = 0;
      @(posedge clk); #1;
      sys_rst = 1'b0;
      @(negedge clk);
      chk("midrst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("midrst_pkt", 128'(pkt_cnt), 128'(0));
      chk("midrst_err", 128'(err_keep), 128'(0));
      @(posedge clk); #1;
      bp_mode = 0;
      m_axis_tready = 1'b1;
      send_beat(rand_data(), 32'h00FF_FFFF, 1'b1);
      wait_drain();
      chk("pkt_cnt_after_rst", 128'(pkt_cnt), 128'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
